// File: rtl/sine_wg_pkg.sv
// Shared types and defaults for the multichannel sine wave generator frame scheduler.
// Holds the scheduler state encoding, default geometry and the frequency-word width helper.
package sine_wg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    localparam int unsigned NR_CHANNELS_DEF = 3;
    localparam int unsigned INPUT_WIDTH_DEF = 24;
    localparam int unsigned CLK_DIV_DEF     = 1024;
    localparam int unsigned SAMPLE_RATE_DEF = 48000;

    // Frequency words only need to reach Nyquist of the sample rate.
    function automatic int unsigned freq_width(input int unsigned fs);
        return $clog2(fs / 2);
    endfunction

endpackage

// File: rtl/sine_wg_tick.sv
// Sample-frame divider: free-running 0..CLK_DIV-1 counter with a registered wrap pulse.
// Ports: clk, rst_n (async active-low), frame_tick (one-cycle pulse every CLK_DIV clocks).
module sine_wg_tick
    import sine_wg_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int unsigned      CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Registering the wrap compare puts the first pulse exactly CLK_DIV clocks after reset.
    always_comb begin
        cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/sine_wg_sched.sv
// Frame scheduler for the multichannel sine generator.
// Ports: cfg_* write the per-channel frequency table; sg_freq_ch/sg_frequency is the
// generator's combinational lookup; s_sg_* collects one sample per channel per frame
// (dv/dr handshake); m_* drains the frame in channel order on a valid/ready stream;
// frame_tick/frame_done mark frame boundaries; overrun is sticky until ovr_clr.
module sine_wg_sched
    import sine_wg_pkg::*;
#(
    parameter int unsigned NR_CHANNELS     = NR_CHANNELS_DEF,
    parameter int unsigned INPUT_WIDTH     = INPUT_WIDTH_DEF,
    parameter int unsigned FREQUENCY_WIDTH = freq_width(SAMPLE_RATE_DEF),
    parameter int unsigned CHANNEL_WIDTH   = $clog2(NR_CHANNELS),
    parameter int unsigned CLK_DIV         = CLK_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr,
    input  logic [CHANNEL_WIDTH-1:0]   cfg_ch,
    input  logic [FREQUENCY_WIDTH-1:0] cfg_freq,
    input  logic [CHANNEL_WIDTH-1:0]   sg_freq_ch,
    output logic [FREQUENCY_WIDTH-1:0] sg_frequency,
    input  logic [INPUT_WIDTH-1:0]     s_sg_d,
    input  logic [CHANNEL_WIDTH-1:0]   s_sg_ch,
    input  logic                       s_sg_dv,
    output logic                       s_sg_dr,
    output logic [INPUT_WIDTH-1:0]     m_d,
    output logic [CHANNEL_WIDTH-1:0]   m_ch,
    output logic                       m_dv,
    input  logic                       m_dr,
    output logic                       frame_tick,
    output logic                       frame_done,
    output logic                       overrun,
    input  logic                       ovr_clr
);

    state_e                     state_q, state_d;
    logic [FREQUENCY_WIDTH-1:0] freq_tab_q [NR_CHANNELS];
    logic [FREQUENCY_WIDTH-1:0] freq_tab_d [NR_CHANNELS];
    logic [INPUT_WIDTH-1:0]     smp_buf_q  [NR_CHANNELS];
    logic [INPUT_WIDTH-1:0]     smp_buf_d  [NR_CHANNELS];
    logic [NR_CHANNELS-1:0]     pending_q, pending_d;
    logic                       dr_q, dr_d;
    logic                       m_dv_q, m_dv_d;
    logic [CHANNEL_WIDTH-1:0]   m_ch_q, m_ch_d;
    logic [INPUT_WIDTH-1:0]     m_d_q, m_d_d;
    logic                       done_q, done_d;
    logic                       overrun_q, overrun_d;
    logic                       cfg_hit, lookup_hit, sg_hit, accept;
    logic [CHANNEL_WIDTH-1:0]   nxt_ch;

    sine_wg_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    assign cfg_hit    = 32'(cfg_ch) < NR_CHANNELS;
    assign lookup_hit = 32'(sg_freq_ch) < NR_CHANNELS;
    assign sg_hit     = 32'(s_sg_ch) < NR_CHANNELS;

    // Lookup reads the registered table, so a same-cycle write shows up one cycle later.
    assign sg_frequency = lookup_hit ? freq_tab_q[sg_freq_ch] : '0;

    // Frequency table update.
    always_comb begin
        freq_tab_d = freq_tab_q;
        if (cfg_wr && cfg_hit) begin
            freq_tab_d[cfg_ch] = cfg_freq;
        end
    end

    // Collect/drain scheduler.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        smp_buf_d = smp_buf_q;
        dr_d      = 1'b0;
        m_dv_d    = m_dv_q;
        m_ch_d    = m_ch_q;
        m_d_d     = m_d_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        nxt_ch    = m_ch_q + CHANNEL_WIDTH'(1);
        // dr_q gate: the generator still sees dv high during the cycle our dr is in flight.
        accept    = (state_q == COLLECT) && s_sg_dv && sg_hit && pending_q[s_sg_ch] && !dr_q;

        // A tick while a frame is still busy is dropped; set beats a simultaneous clear.
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (frame_tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d   = COLLECT;
                    pending_d = '1;
                end
            end
            COLLECT: begin
                if (pending_q == '0) begin
                    state_d = DRAIN;
                    m_dv_d  = 1'b1;
                    m_ch_d  = '0;
                    m_d_d   = smp_buf_q[0];
                end else if (accept) begin
                    smp_buf_d[s_sg_ch] = s_sg_d;
                    pending_d[s_sg_ch] = 1'b0;
                    dr_d               = 1'b1;
                end
            end
            DRAIN: begin
                if (m_dv_q && m_dr) begin
                    if (32'(m_ch_q) == NR_CHANNELS - 1) begin
                        state_d = IDLE;
                        m_dv_d  = 1'b0;
                        m_ch_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        m_ch_d = nxt_ch;
                        m_d_d  = smp_buf_q[nxt_ch];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            freq_tab_q <= '{default: '0};
            smp_buf_q  <= '{default: '0};
            pending_q  <= '0;
            dr_q       <= 1'b0;
            m_dv_q     <= 1'b0;
            m_ch_q     <= '0;
            m_d_q      <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            freq_tab_q <= freq_tab_d;
            smp_buf_q  <= smp_buf_d;
            pending_q  <= pending_d;
            dr_q       <= dr_d;
            m_dv_q     <= m_dv_d;
            m_ch_q     <= m_ch_d;
            m_d_q      <= m_d_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign s_sg_dr    = dr_q;
    assign m_dv       = m_dv_q;
    assign m_ch       = m_ch_q;
    assign m_d        = m_d_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sine_wg_sched.sv
// Directed-plus-random bench for sine_wg_sched with a small behavioural model
// (frequency table array and per-frame expected sample buffer).
module tb_sine_wg_sched;

    localparam int N  = 3;
    localparam int IW = 24;
    localparam int FW = 15;
    localparam int CW = 2;
    localparam int CD = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_wr;
    logic [CW-1:0] cfg_ch;
    logic [FW-1:0] cfg_freq;
    logic [CW-1:0] sg_freq_ch;
    logic [FW-1:0] sg_frequency;
    logic [IW-1:0] s_sg_d;
    logic [CW-1:0] s_sg_ch;
    logic          s_sg_dv;
    logic          s_sg_dr;
    logic [IW-1:0] m_d;
    logic [CW-1:0] m_ch;
    logic          m_dv;
    logic          m_dr;
    logic          frame_tick;
    logic          frame_done;
    logic          overrun;
    logic          ovr_clr;

    int n_chk  = 0;
    int n_pass = 0;
    int dr_cnt = 0;

    logic [IW-1:0] ref_buf [N];
    logic [FW-1:0] ref_tab [N];

    sine_wg_sched #(
        .NR_CHANNELS     (N),
        .INPUT_WIDTH     (IW),
        .FREQUENCY_WIDTH (FW),
        .CHANNEL_WIDTH   (CW),
        .CLK_DIV         (CD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wr       (cfg_wr),
        .cfg_ch       (cfg_ch),
        .cfg_freq     (cfg_freq),
        .sg_freq_ch   (sg_freq_ch),
        .sg_frequency (sg_frequency),
        .s_sg_d       (s_sg_d),
        .s_sg_ch      (s_sg_ch),
        .s_sg_dv      (s_sg_dv),
        .s_sg_dr      (s_sg_dr),
        .m_d          (m_d),
        .m_ch         (m_ch),
        .m_dv         (m_dv),
        .m_dr         (m_dr),
        .frame_tick   (frame_tick),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_sg_dr) dr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [FW-1:0] ref_lookup(input int ch);
        return (ch < N) ? ref_tab[CW'(ch)] : '0;
    endfunction

    task automatic rst_checks();
        chk("rst_sg_frequency", 32'(sg_frequency), 0);
        chk("rst_s_sg_dr",      32'(s_sg_dr),      0);
        chk("rst_m_dv",         32'(m_dv),         0);
        chk("rst_m_ch",         32'(m_ch),         0);
        chk("rst_m_d",          32'(m_d),          0);
        chk("rst_frame_tick",   32'(frame_tick),   0);
        chk("rst_frame_done",   32'(frame_done),   0);
        chk("rst_overrun",      32'(overrun),      0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 4 * CD);
        chk("tick_seen", 32'(frame_tick), 1);
    endtask

    task automatic offer(input int ch, input logic [IW-1:0] d, input int bound, output bit acc);
        int n = 0;
        acc = 1'b0;
        s_sg_dv = 1'b1;
        s_sg_ch = CW'(ch);
        s_sg_d  = d;
        while (!acc && n < bound) begin
            @(negedge clk);
            n++;
            if (s_sg_dr) acc = 1'b1;
        end
        s_sg_dv = 1'b0;
    endtask

    task automatic collect_random(input bit with_oor);
        int   order [N];
        int   j;
        int   t;
        bit   acc;
        logic [IW-1:0] d;
        for (int i = 0; i < N; i++) order[i] = i;
        for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        if (with_oor) begin
            offer(3, IW'($urandom()), 4, acc);
            chk("oor_no_dr", 32'(acc), 0);
        end
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            d = IW'($urandom());
            offer(order[i], d, 8, acc);
            chk("collect_dr", 32'(acc), 1);
            ref_buf[CW'(order[i])] = d;
        end
    endtask

    task automatic drain_check(output int lat);
        lat = 0;
        while (!m_dv && lat < 4 * CD) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < N; i++) begin
            chk("drain_dv", 32'(m_dv), 1);
            chk("drain_ch", 32'(m_ch), 32'(i));
            chk("drain_d",  32'(m_d),  32'(ref_buf[CW'(i)]));
            @(negedge clk);
        end
        chk("frame_done", 32'(frame_done), 1);
        chk("dv_low_after_frame", 32'(m_dv), 0);
    endtask

    task automatic wr_check(input int ch, input logic [FW-1:0] v);
        @(negedge clk);
        cfg_wr     = 1'b1;
        cfg_ch     = CW'(ch);
        cfg_freq   = v;
        sg_freq_ch = CW'(ch);
        #1 chk("tab_same_cycle_old", 32'(sg_frequency), 32'(ref_lookup(ch)));
        if (ch < N) ref_tab[CW'(ch)] = v;
        @(negedge clk);
        cfg_wr = 1'b0;
        #1 chk("tab_next_cycle_new", 32'(sg_frequency), 32'(ref_lookup(ch)));
    endtask

    initial begin
        int   n;
        int   lat;
        int   ticks;
        int   hold;
        int   dr_before;
        bit   acc;
        bit   stable;
        logic [IW-1:0] d;

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_freq = '0; sg_freq_ch = '0;
        s_sg_d = '0; s_sg_ch = '0; s_sg_dv = 1'b0; m_dr = 1'b1; ovr_clr = 1'b0;
        for (int i = 0; i < N; i++) begin
            ref_tab[CW'(i)] = '0;
            ref_buf[CW'(i)] = '0;
        end

        // Reset values and first tick distance.
        repeat (3) @(negedge clk);
        rst_checks();
        rst_n = 1'b1;
        wait_tick(n);
        chk("first_tick_dist", 32'(n), CD);

        // Directed frame: ch0..2 in order, m_dr held high.
        offer(0, 24'h100001, 8, acc); chk("f1_dr_ch0", 32'(acc), 1); ref_buf[0] = 24'h100001;
        offer(1, 24'h200002, 8, acc); chk("f1_dr_ch1", 32'(acc), 1); ref_buf[1] = 24'h200002;
        offer(2, 24'h300003, 8, acc); chk("f1_dr_ch2", 32'(acc), 1); ref_buf[2] = 24'h300003;
        drain_check(lat);
        chk("f1_drain_latency", 32'(lat), 1);

        // Frequency table: directed values, sweep incl. out-of-range, then random writes.
        wr_check(0, 15'd1010);
        wr_check(1, 15'd12010);
        wr_check(2, 15'd22510);
        for (int ch = 0; ch < 4; ch++) begin
            sg_freq_ch = CW'(ch);
            #1 chk("tab_sweep", 32'(sg_frequency), 32'(ref_lookup(ch)));
        end
        for (int k = 0; k < 6; k++) begin
            wr_check(int'($urandom_range(0, 3)), FW'($urandom_range(1, 24000)));
        end

        // Random frames, the first with an out-of-range channel offer.
        for (int f = 0; f < 3; f++) begin
            wait_tick(n);
            chk("tick_period", 32'(n) <= CD ? 32'd1 : 32'd0, 1);
            collect_random(f == 0);
            drain_check(lat);
            chk("rand_drain_latency", 32'(lat), 1);
        end

        // Duplicate channel in one frame: second ch1 offer gets no dr.
        wait_tick(n);
        d = IW'($urandom()); offer(0, d, 8, acc); chk("dup_dr_ch0", 32'(acc), 1); ref_buf[0] = d;
        d = IW'($urandom()); offer(1, d, 8, acc); chk("dup_dr_ch1a", 32'(acc), 1); ref_buf[1] = d;
        offer(1, IW'($urandom()), 6, acc);
        chk("dup_ch1b_no_dr", 32'(acc), 0);
        d = IW'($urandom()); offer(2, d, 8, acc); chk("dup_dr_ch2", 32'(acc), 1); ref_buf[2] = d;
        // Hold a further ch1 offer across drain; it must wait for the next frame.
        d = IW'($urandom());
        s_sg_dv = 1'b1; s_sg_ch = 2'd1; s_sg_d = d;
        #1 dr_before = dr_cnt;
        drain_check(lat);
        chk("dup_drain_latency", 32'(lat), 1);
        wait_tick(n);
        #1 chk("dup_held_no_dr", 32'(dr_cnt), 32'(dr_before));
        @(negedge clk);
        chk("dup_next_frame_dr_wait", 32'(s_sg_dr), 0);
        @(negedge clk);
        chk("dup_next_frame_dr", 32'(s_sg_dr), 1);
        s_sg_dv = 1'b0;
        ref_buf[1] = d;
        d = IW'($urandom()); offer(0, d, 8, acc); chk("dup2_dr_ch0", 32'(acc), 1); ref_buf[0] = d;
        d = IW'($urandom()); offer(2, d, 8, acc); chk("dup2_dr_ch2", 32'(acc), 1); ref_buf[2] = d;
        drain_check(lat);

        // Overrun: back-pressure the drain across two ticks.
        wait_tick(n);
        m_dr = 1'b0;
        collect_random(1'b0);
        lat = 0;
        while (!m_dv && lat < 4 * CD) begin
            @(negedge clk);
            lat++;
        end
        chk("ovr_dv_up", 32'(m_dv), 1);
        chk("ovr_clear_before", 32'(overrun), 0);
        stable = 1'b1; ticks = 0; hold = 0;
        while (ticks < 2 && hold < 3 * CD) begin
            @(negedge clk);
            hold++;
            if (m_dv !== 1'b1 || m_ch !== 2'd0 || m_d !== ref_buf[0]) stable = 1'b0;
            if (frame_tick) ticks++;
        end
        chk("ovr_ticks_seen", 32'(ticks), 2);
        chk("ovr_set", 32'(overrun), 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_set_wins_over_clr", 32'(overrun), 1);
        chk("ovr_out_stable", 32'(stable), 1);
        chk("ovr_hold_ch", 32'(m_ch), 0);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);
        m_dr = 1'b1;
        drain_check(lat);

        // Reset in the middle of DRAIN with m_ch=1.
        wait_tick(n);
        sg_freq_ch = 2'd2;
        collect_random(1'b0);
        lat = 0;
        while (!m_dv && lat < 4 * CD) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        m_dr = 1'b0;
        chk("pre_rst_ch1", 32'(m_ch), 1);
        rst_n = 1'b0;
        #1 rst_checks();
        for (int i = 0; i < N; i++) ref_tab[CW'(i)] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_dr  = 1'b1;
        wait_tick(n);
        chk("tick_after_rst", 32'(n), CD);
        collect_random(1'b0);
        drain_check(lat);
        chk("post_rst_drain_latency", 32'(lat), 1);

        // Same-cycle write/lookup on ch2.
        wr_check(2, 15'd5000);
        wr_check(2, FW'($urandom_range(1, 24000)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
